// File: rtl/display_scan_if.sv
// Signal bundle between the clock's display datapath and the digit scan controller.
// No handshake: en is a level sampled every clock edge, and sel/an/frame_start are plain registered levels.
interface display_scan_if;
    logic       en;
    logic       blank_lead;
    logic [3:0] mux_y;
    logic [1:0] sel;
    logic [3:0] an;
    logic       frame_start;
    logic       dbg_scan;

    modport master (
        output en, blank_lead, mux_y,
        input  sel, an, frame_start, dbg_scan
    );

    modport slave (
        input  en, blank_lead, mux_y,
        output sel, an, frame_start, dbg_scan
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: steps the digit mux select, drives active-low anodes
// with an all-off guard at each slot start, and optionally blanks a leading zero on digit 3.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LIT_FIRST = CW'(GUARD_CYC);
    localparam logic [CW-1:0] LIT_LAST  = CW'(REFRESH_DIV - 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic          fs_q, fs_d;

    logic          suppress;
    logic          in_window;
    logic          slot_end;
    logic [3:0]    an_lit;

    always_comb begin
        suppress  = bus.blank_lead & (sel_q == 2'd3) & (bus.mux_y == 4'd0);
        in_window = (cnt_q >= LIT_FIRST) && (cnt_q <= LIT_LAST);
        slot_end  = (cnt_q == CNT_LAST);
        an_lit    = ~(4'b0001 << sel_q);
    end

    // The anode window closes at cnt = REFRESH_DIV-2, so the edge that advances sel
    // always loads an = 1111 and two digits can never be lit together.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sel_d   = 2'd0;
        an_d    = 4'b1111;
        fs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_SCAN;
                    fs_d    = 1'b1;
                end
            end
            S_SCAN: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                end else begin
                    if (slot_end) begin
                        cnt_d = '0;
                        sel_d = sel_q + 2'd1;
                        fs_d  = (sel_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        sel_d = sel_q;
                    end
                    if (in_window && !suppress) begin
                        an_d = an_lit;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1111;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;
    assign bus.dbg_scan    = (state_q == S_SCAN);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=8, GUARD_CYC=2; outputs sampled on the falling edge.
module tb_display_scan_ctrl;

    localparam int RD = 8;
    localparam int GC = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    display_scan_if bus ();

    display_scan_ctrl #(
        .REFRESH_DIV(RD),
        .GUARD_CYC  (GC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Packed {sel, an, frame_start} expected c cycles after scan entry (c=0 is the entry cycle).
    function automatic logic [7:0] exp_vec(input int c, input bit blank3);
        logic [1:0] s;
        logic [3:0] a;
        int         slot_pos;
        s        = 2'((c / RD) % 4);
        slot_pos = c % RD;
        if (slot_pos <= GC || (blank3 && s == 2'd3)) a = 4'b1111;
        else                                          a = ~(4'b0001 << s);
        return {1'b0, s, a, (c % (4 * RD)) == 0};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {1'b0, bus.sel, bus.an, bus.frame_start};
    endfunction

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.blank_lead = 1'b0;
        bus.mux_y      = 4'd5;

        repeat (2) @(negedge clk);
        check("reset_outputs", obs_vec(), {1'b0, 2'd0, 4'b1111, 1'b0});
        check("reset_state", {7'd0, bus.dbg_scan}, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_en0", obs_vec(), {1'b0, 2'd0, 4'b1111, 1'b0});
        end

        // Entry, two full frames, then blanking with zero and non-zero digit 3.
        bus.en = 1'b1;
        for (int c = 0; c < 149; c++) begin
            @(negedge clk);
            check($sformatf("scan_c%0d", c), obs_vec(), exp_vec(c, (c >= 64 && c < 96)));
            if (c == 63) begin
                bus.blank_lead = 1'b1;
                bus.mux_y      = 4'd0;
            end
            if (c == 95) bus.mux_y = 4'd1;
        end
        check("scan_state", {7'd0, bus.dbg_scan}, 8'd1);
        check("an_1011_before_drop", {4'd0, bus.an}, 8'h0b);

        bus.en = 1'b0;
        @(negedge clk);
        check("drop_en", obs_vec(), {1'b0, 2'd0, 4'b1111, 1'b0});
        check("drop_en_state", {7'd0, bus.dbg_scan}, 8'd0);
        bus.en = 1'b1;

        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            check($sformatf("reentry_c%0d", c), obs_vec(), exp_vec(c, 1'b0));
        end
        check("an_1011_before_reset", {4'd0, bus.an}, 8'h0b);

        #2 rst_n = 1'b0;
        #1 check("async_reset", obs_vec(), {1'b0, 2'd0, 4'b1111, 1'b0});
        check("async_reset_state", {7'd0, bus.dbg_scan}, 8'd0);
        @(negedge clk);
        check("held_reset", obs_vec(), {1'b0, 2'd0, 4'b1111, 1'b0});
        rst_n = 1'b1;

        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_c%0d", c), obs_vec(), exp_vec(c, 1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
